vector_lane_packer: RTL

Downstream stage of the crossbar switch: consumes the switch's scalar element stream (valid/ready), packs NUM_LANES consecutive elements into one vector word, and buffers completed vectors in a small FIFO for the vector execution stage. It also regenerates the switch's feedback input by returning one selected lane of each vector popped by the consumer.

---
 rtl/vp_pkg.sv | 10 +
 rtl/vec_fifo.sv | 55 +++++
 rtl/vector_lane_packer.sv | 104 ++++++++++
 3 files changed

// File: rtl/vp_pkg.sv
// Shared defaults and types for the vector lane packer slice.
package vp_pkg;

    localparam int VP_DATA_WIDTH = 16;
    localparam int VP_NUM_LANES  = 8;

    typedef logic [VP_NUM_LANES-1:0][VP_DATA_WIDTH-1:0] vec_t;
    typedef logic [$clog2(VP_NUM_LANES)-1:0]           lane_idx_t;

endpackage

// File: rtl/vec_fifo.sv
// Synchronous show-ahead FIFO: rdata always presents the head entry.
module vec_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [AW-1:0]               wr_ptr;
    logic [AW-1:0]               rd_ptr;
    logic [AW:0]                 cnt;
    logic                        do_push;
    logic                        do_pop;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];
    assign count   = cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/vector_lane_packer.sv
// Packs NUM_LANES scalar elements into vectors, buffers them in vec_fifo, and returns
// one lane of each popped vector as feedback when VP_PACKER_FEEDBACK_EN is defined.
module vector_lane_packer
    import vp_pkg::*;
#(
    parameter int DATA_WIDTH = VP_DATA_WIDTH,
    parameter int NUM_LANES  = VP_NUM_LANES,
    parameter int DEPTH      = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [DATA_WIDTH-1:0]            in_data,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic                             flush,
    output logic [NUM_LANES*DATA_WIDTH-1:0]  vec_data,
    output logic                             vec_valid,
    input  logic                             vec_ready,
    output logic [$clog2(DEPTH):0]           vec_count,
    output logic [$clog2(NUM_LANES)-1:0]     lane_cnt,
    input  logic [$clog2(NUM_LANES)-1:0]     fb_lane_sel,
    output logic [DATA_WIDTH-1:0]            fb_data,
    output logic                             fb_valid
);

    localparam int LW = $clog2(NUM_LANES);

    typedef logic [NUM_LANES-1:0][DATA_WIDTH-1:0] lanes_t;

    lanes_t        partial;
    lanes_t        push_vec;
    lanes_t        head_vec;
    logic [LW-1:0] lane_q;
    logic          last_lane;
    logic          accept;
    logic          push;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;

    assign last_lane = (lane_q == LW'(NUM_LANES - 1));
    // Only the closing lane needs FIFO space; earlier lanes land in the partial register.
    assign in_ready  = !(last_lane && fifo_full);
    assign accept    = in_valid && in_ready && !flush;
    assign push      = accept && last_lane;
    assign pop       = !fifo_empty && vec_ready;

    always_comb begin
        push_vec                = partial;
        push_vec[NUM_LANES-1]   = in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            partial <= '0;
            lane_q  <= '0;
        end else if (flush) begin
            partial <= '0;
            lane_q  <= '0;
        end else if (accept) begin
            partial[lane_q] <= in_data;
            lane_q          <= lane_q + LW'(1);
        end
    end

    vec_fifo #(
        .WIDTH (NUM_LANES * DATA_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (push_vec),
        .rdata (head_vec),
        .count (vec_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign vec_data  = head_vec;
    assign vec_valid = !fifo_empty;
    assign lane_cnt  = lane_q;

`ifdef VP_PACKER_FEEDBACK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fb_data  <= '0;
            fb_valid <= 1'b0;
        end else begin
            fb_valid <= pop;
            if (pop) begin
                fb_data <= head_vec[fb_lane_sel];
            end
        end
    end
`else
    logic unused_fb_lane_sel;
    assign unused_fb_lane_sel = ^fb_lane_sel;
    assign fb_data            = '0;
    assign fb_valid           = 1'b0;
`endif

endmodule
